// File: rtl/vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// vga_pixel_pipe
//   Stage between the SRAM frame reader and the VGA DAC pins. Each SRAM word
//   holds two 8-bit pixel indices. This block picks the byte for the current
//   pixel, maps the index to 24-bit RGB through a palette, and delays
//   HS/VS/BLANK_N by the same 3 clocks so sync stays pixel-aligned.
//
//   Optional feature macro: PALETTE_WRITE_EN
//     defined   : palette is a writable 256x24 register array (pal_* ports)
//     undefined : fixed 3-3-2 index decode; pal_* ports are ignored
//
// Ports
//   Clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, FramePtr     pixel column and scroll offset (only bit 0 matters)
//   VGA_HS_in/VS_in     active-low syncs from the timing generator
//   BLANK_N_in          1 = active video
//   SRAM_Data           registered SRAM word, valid one clock after DrawX
//   pal_we/addr/data    palette write port (PALETTE_WRITE_EN only)
//   VGA_R/G/B           registered pixel colour
//   VGA_HS/VS/BLANK_N   sync and blank, delayed 3 clocks
//   pix_index           palette index of the pixel currently on VGA_R/G/B
// ---------------------------------------------------------------------------
module vga_pixel_pipe #(
    parameter bit          BYTE_ORDER = 1'b0,
    parameter logic [23:0] BLANK_RGB  = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [12:0] FramePtr,
    input  logic        VGA_HS_in,
    input  logic        VGA_VS_in,
    input  logic        BLANK_N_in,
    input  logic [15:0] SRAM_Data,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  pix_index
);

    // Stage A
    logic        sel_a_q, sel_a_d;
    logic        valid_a_q;          // 0 while the pipe refills after reset
    // Stage B
    logic [7:0]  idx_b_q, idx_b_d;
    // Stage C (output registers)
    logic [23:0] rgb_c_q, rgb_c_d;
    logic [7:0]  idx_c_q;
    // Sync/blank shift registers: bit 0 = stage A, bit 2 = stage C
    logic [2:0]  hs_q, vs_q, bl_q;

    logic [23:0] pal_rgb;

`ifdef PALETTE_WRITE_EN
    logic [23:0] pal_q [256];

    // NOTE: the palette is storage, not control state; it is deliberately
    // left out of reset so contents survive a pipeline reset and the array
    // maps onto plain RAM/register cells without a reset network.
    always_ff @(posedge Clk) begin
        if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    // Read before the edge: a same-edge write to this index shows up only
    // for the next pixel.
    assign pal_rgb = pal_q[idx_b_q];

    logic unused_inputs;
    assign unused_inputs = ^{DrawX[9:1], FramePtr[12:1]};
`else
    // 3-3-2 decode, idx = RRRGGGBB; replicate bits to fill 8-bit channels.
    assign pal_rgb = {idx_b_q[7:5], idx_b_q[7:5], idx_b_q[7:6],
                      idx_b_q[4:2], idx_b_q[4:2], idx_b_q[4:3],
                      {4{idx_b_q[1:0]}}};

    logic unused_inputs;
    assign unused_inputs = ^{pal_we, pal_addr, pal_data,
                             DrawX[9:1], FramePtr[12:1]};
`endif

    // NOTE: every always_comb output gets an unconditional assignment first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        sel_a_d = 1'b0;
        idx_b_d = 8'h00;
        rgb_c_d = BLANK_RGB;

        // DrawY*4114 is even, so only the low bits of DrawX and FramePtr
        // decide which byte of the word holds this pixel.
        sel_a_d = DrawX[0] ^ FramePtr[0] ^ BYTE_ORDER;

        // Until stage A holds a real pixel, keep the index at its reset value.
        if (valid_a_q) begin
            idx_b_d = sel_a_q ? SRAM_Data[15:8] : SRAM_Data[7:0];
        end

        // Blanking gates colour only; the index still flows to pix_index.
        if (bl_q[1]) begin
            rgb_c_d = pal_rgb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the stages shift together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_a_q   <= 1'b0;
            valid_a_q <= 1'b0;
            idx_b_q   <= 8'h00;
            rgb_c_q   <= BLANK_RGB;
            idx_c_q   <= 8'h00;
            hs_q      <= 3'b111;
            vs_q      <= 3'b111;
            bl_q      <= 3'b000;
        end else begin
            sel_a_q   <= sel_a_d;
            valid_a_q <= 1'b1;
            idx_b_q   <= idx_b_d;
            rgb_c_q   <= rgb_c_d;
            idx_c_q   <= idx_b_q;
            hs_q      <= {hs_q[1:0], VGA_HS_in};
            vs_q      <= {vs_q[1:0], VGA_VS_in};
            bl_q      <= {bl_q[1:0], BLANK_N_in};
        end
    end

    assign VGA_R       = rgb_c_q[23:16];
    assign VGA_G       = rgb_c_q[15:8];
    assign VGA_B       = rgb_c_q[7:0];
    assign VGA_HS      = hs_q[2];
    assign VGA_VS      = vs_q[2];
    assign VGA_BLANK_N = bl_q[2];
    assign pix_index   = idx_c_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_pipe
//   Directed vectors with hand-computed colours. The stimulus process pushes
//   the expected output for each clock edge into a queue; a monitor on the
//   falling edge pops and compares. A reset edge discards pending pixels and
//   queues reset values for itself and the two refill edges that follow.
// ---------------------------------------------------------------------------
module tb_vga_pixel_pipe;

    localparam logic [23:0] BL = 24'h102030;   // distinctive blank colour

`ifdef PALETTE_WRITE_EN
    localparam logic [23:0] C_5A = 24'h123456;
`else
    localparam logic [23:0] C_5A = 24'h49DBAA;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [12:0] FramePtr;
    logic        VGA_HS_in, VGA_VS_in, BLANK_N_in;
    logic [15:0] SRAM_Data;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0]  pix_index;

    vga_pixel_pipe #(.BYTE_ORDER(1'b0), .BLANK_RGB(BL)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .FramePtr(FramePtr),
        .VGA_HS_in(VGA_HS_in), .VGA_VS_in(VGA_VS_in), .BLANK_N_in(BLANK_N_in),
        .SRAM_Data(SRAM_Data), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .pix_index(pix_index)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          at_edge;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [7:0]  idx;
    } exp_t;

    exp_t        sb[$];
    int          edge_cnt  = 0;
    int          neg_cnt   = 0;
    int          compared  = 0;
    int          mismatched = 0;
    logic [15:0] prev_data = 16'h0000;

    // ---------------- monitor ----------------
    exp_t m;
    always @(negedge Clk) begin
        neg_cnt++;
        if (sb.size() > 0 && sb[0].at_edge <= neg_cnt) begin
            m = sb.pop_front();
            compared++;
            if (m.at_edge != neg_cnt ||
                {VGA_R, VGA_G, VGA_B} !== m.rgb || VGA_HS !== m.hs ||
                VGA_VS !== m.vs || VGA_BLANK_N !== m.bl || pix_index !== m.idx) begin
                mismatched++;
                $display("FAIL edge%0d: got rgb=%h hs=%b vs=%b bl=%b idx=%h, want rgb=%h hs=%b vs=%b bl=%b idx=%h (queued for edge %0d)",
                         neg_cnt, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N,
                         pix_index, m.rgb, m.hs, m.vs, m.bl, m.idx, m.at_edge);
            end
        end
    end

    // ---------------- stimulus ----------------
    // One reset edge; palette write fields are applied on the same edge.
    task automatic rst_cycle(input logic we, input logic [7:0] a, input logic [23:0] d);
        exp_t e;
        Reset     = 1'b1;
        SRAM_Data = prev_data;
        prev_data = 16'hFFFF;            // junk word that must not leak out
        pal_we    = we;
        pal_addr  = a;
        pal_data  = d;
        @(posedge Clk);
        edge_cnt++;
        while (sb.size() > 0 && sb[$].at_edge >= edge_cnt) void'(sb.pop_back());
        for (int k = 0; k < 3; k++) begin
            e.at_edge = edge_cnt + k;
            e.rgb = BL; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.idx = 8'h00;
            sb.push_back(e);
        end
        #1;
        pal_we = 1'b0;
    endtask

    // One live pixel; its SRAM word is presented on the following edge.
    task automatic px(input logic [9:0] x, input logic [12:0] fp,
                      input logic hs, input logic vs, input logic bl,
                      input logic [15:0] data, input logic [7:0] e_idx,
                      input logic [23:0] e_rgb);
        exp_t e;
        Reset      = 1'b0;
        DrawX      = x;
        FramePtr   = fp;
        VGA_HS_in  = hs;
        VGA_VS_in  = vs;
        BLANK_N_in = bl;
        SRAM_Data  = prev_data;
        prev_data  = data;
        @(posedge Clk);
        edge_cnt++;
        e.at_edge = edge_cnt + 2;
        e.rgb = bl ? e_rgb : BL;
        e.hs = hs; e.vs = vs; e.bl = bl; e.idx = e_idx;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        Reset = 1'b1; DrawX = '0; FramePtr = '0;
        VGA_HS_in = 1'b1; VGA_VS_in = 1'b1; BLANK_N_in = 1'b0;
        SRAM_Data = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;

`ifdef PALETTE_WRITE_EN
        // Load the palette (during reset) with the colours the vectors expect.
        rst_cycle(1'b1, 8'h00, 24'h000000);
        rst_cycle(1'b1, 8'h1C, 24'h00FF00);
        rst_cycle(1'b1, 8'h3C, 24'h24FF00);
        rst_cycle(1'b1, 8'h5A, 24'h123456);
        rst_cycle(1'b1, 8'hA5, 24'hB62455);
        rst_cycle(1'b1, 8'hC3, 24'hDB00FF);
        rst_cycle(1'b1, 8'hE3, 24'hFF00FF);
        rst_cycle(1'b1, 8'hFF, 24'hFFFFFF);
`else
        rst_cycle(1'b0, 8'h00, 24'h0);
        rst_cycle(1'b0, 8'h00, 24'h0);
`endif

        // Byte select and colour mapping
        px(10'd0,   13'h0000, 1, 1, 1, 16'h5AE3, 8'hE3, 24'hFF00FF);
        px(10'd1,   13'h0000, 1, 1, 1, 16'h1C00, 8'h1C, 24'h00FF00);
        px(10'd4,   13'h0000, 1, 1, 1, 16'hA55A, 8'h5A, C_5A);
        px(10'd4,   13'h0001, 1, 1, 1, 16'hA55A, 8'hA5, 24'hB62455);
        px(10'd5,   13'h0001, 1, 1, 1, 16'h3CC3, 8'hC3, 24'hDB00FF);
        px(10'd799, 13'h0000, 1, 1, 1, 16'h3CC3, 8'h3C, 24'h24FF00);
        px(10'd0,   13'h1FFF, 1, 1, 1, 16'hFF00, 8'hFF, 24'hFFFFFF);

`ifdef PALETTE_WRITE_EN
        // Same-edge write/read of index 5A: old colour, then new colour.
        px(10'd4, 13'h0000, 1, 1, 1, 16'hA55A, 8'h5A, 24'h123456);
        px(10'd6, 13'h0000, 1, 1, 1, 16'h3C5A, 8'h5A, 24'hABCDEF);
        pal_we = 1'b1; pal_addr = 8'h5A; pal_data = 24'hABCDEF;
        px(10'd8, 13'h0000, 1, 1, 1, 16'h0000, 8'h00, 24'h000000);
        pal_we = 1'b0;
`endif

        // Mid-line reset: pixels in flight are dropped, pipe refills
        px(10'd1,   13'h1FFF, 1, 1, 1, 16'h00FF, 8'hFF, 24'hFFFFFF);
        px(10'd2,   13'h0000, 1, 1, 1, 16'h5A00, 8'h00, 24'h000000);
        rst_cycle(1'b0, 8'h00, 24'h0);
        rst_cycle(1'b0, 8'h00, 24'h0);
        px(10'd3,   13'h0000, 1, 1, 1, 16'hE3A5, 8'hE3, 24'hFF00FF);

        // Blanked region with HS/VS pulses; index still tracked
        px(10'd4,   13'h0000, 1, 1, 0, 16'hE3A5, 8'hA5, BL);
        px(10'd5,   13'h0000, 0, 1, 0, 16'h1C5A, 8'h1C, BL);
        px(10'd6,   13'h0000, 0, 0, 0, 16'h1C5A, 8'h5A, BL);
        px(10'd7,   13'h0000, 1, 0, 0, 16'h00C3, 8'h00, BL);
        px(10'd8,   13'h0000, 1, 1, 1, 16'h00C3, 8'hC3, 24'hDB00FF);
        px(10'd9,   13'h0000, 1, 1, 0, 16'h0000, 8'h00, BL);
        px(10'd10,  13'h0000, 1, 1, 0, 16'h0000, 8'h00, BL);

        // Drain: bounded wait for the monitor to consume every entry
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge Clk);
        #1;
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
